// File: rtl/triumphcore_sim_ctrl.sv
// Simulation run/finish controller: counts cycles and retirements, keeps a ring
// of recent retired PCs and settles into PASS, FAIL or TIMEOUT for the bench.
module triumphcore_sim_ctrl #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     HIST_DEPTH     = 8,
  parameter int unsigned     TIMEOUT_CYCLES = 250,
  parameter int unsigned     STALL_LIMIT    = 64,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h8000_1000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          retire_valid_i,
  input  logic [XLEN-1:0]               retire_pc_i,
  input  logic                          dwrite_valid_i,
  input  logic [XLEN-1:0]               dwrite_addr_i,
  input  logic [XLEN-1:0]               dwrite_data_i,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx_i,
  output logic [XLEN-1:0]               hist_rd_pc_o,
  output logic [$clog2(HIST_DEPTH):0]   hist_count_o,
  output logic [63:0]                   cycle_cnt_o,
  output logic [63:0]                   instret_o,
  output logic [1:0]                    state_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic [XLEN-1:0]               fail_code_o,
  output logic                          timeout_cause_o
);

  localparam int unsigned IDX_W = $clog2(HIST_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       cycle_q, cycle_d;
  logic [63:0]       instret_q, instret_d;
  logic [31:0]       stall_q, stall_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  hcount_q, hcount_d;
  logic [XLEN-1:0]   fail_code_q, fail_code_d;
  logic              cause_q, cause_d;
  logic [XLEN-1:0]   hist_q [HIST_DEPTH];

  logic              in_run;
  logic              tohost;
  logic              hist_we;
  logic [IDX_W-1:0]  rd_slot;

  assign in_run  = (state_q == ST_RUN);
  assign tohost  = dwrite_valid_i && (dwrite_addr_i == TOHOST_ADDR);
  assign hist_we = in_run && retire_valid_i;

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    instret_d   = instret_q;
    stall_d     = stall_q;
    wr_ptr_d    = wr_ptr_q;
    hcount_d    = hcount_q;
    fail_code_d = fail_code_q;
    cause_d     = cause_q;

    if (in_run) begin
      cycle_d = cycle_q + 64'd1;
      if (retire_valid_i) begin
        instret_d = instret_q + 64'd1;
        stall_d   = '0;
        wr_ptr_d  = wr_ptr_q + IDX_W'(1);
        if (hcount_q != CNT_W'(HIST_DEPTH)) begin
          hcount_d = hcount_q + CNT_W'(1);
        end
      end else begin
        stall_d = stall_q + 32'd1;
      end

      // Even tohost values are not a verdict, so they fall through to the timeout checks.
      if (tohost && (dwrite_data_i == XLEN'(1))) begin
        state_d = ST_PASS;
      end else if (tohost && dwrite_data_i[0]) begin
        state_d     = ST_FAIL;
        fail_code_d = dwrite_data_i >> 1;
      end else if ((TIMEOUT_CYCLES != 0) &&
                   (cycle_q == (64'(TIMEOUT_CYCLES) - 64'd1))) begin
        state_d = ST_TIMEOUT;
        cause_d = 1'b0;
      end else if ((STALL_LIMIT != 0) && !retire_valid_i &&
                   (stall_q == (32'(STALL_LIMIT) - 32'd1))) begin
        state_d = ST_TIMEOUT;
        cause_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      cycle_q     <= '0;
      instret_q   <= '0;
      stall_q     <= '0;
      wr_ptr_q    <= '0;
      hcount_q    <= '0;
      fail_code_q <= '0;
      cause_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      stall_q     <= stall_d;
      wr_ptr_q    <= wr_ptr_d;
      hcount_q    <= hcount_d;
      fail_code_q <= fail_code_d;
      cause_q     <= cause_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else if (hist_we) begin
      hist_q[wr_ptr_q] <= retire_pc_i;
    end
  end

  // Power-of-two depth lets the pointer arithmetic wrap naturally.
  assign rd_slot      = wr_ptr_q - IDX_W'(1) - hist_rd_idx_i;
  assign hist_rd_pc_o = (CNT_W'(hist_rd_idx_i) < hcount_q) ? hist_q[rd_slot] : '0;

  assign hist_count_o    = hcount_q;
  assign cycle_cnt_o     = cycle_q;
  assign instret_o       = instret_q;
  assign state_o         = state_q;
  assign done_o          = !in_run;
  assign pass_o          = (state_q == ST_PASS);
  assign fail_code_o     = fail_code_q;
  assign timeout_cause_o = cause_q;

endmodule

// File: tb/tb_triumphcore_sim_ctrl.sv
// Directed bench for triumphcore_sim_ctrl: default, no-stall and short-stall instances
// share stimulus; each scenario checks the instance it targets.
module tb_triumphcore_sim_ctrl;

  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic        clk;
  logic        rst;
  logic        retire;
  logic [31:0] pc;
  logic        dwv;
  logic [31:0] daddr;
  logic [31:0] ddata;
  logic [2:0]  hidx;

  logic [31:0] a_hpc, b_hpc, c_hpc;
  logic [3:0]  a_hcnt, b_hcnt, c_hcnt;
  logic [63:0] a_cyc, b_cyc, c_cyc;
  logic [63:0] a_ret, b_ret, c_ret;
  logic [1:0]  a_st, b_st, c_st;
  logic        a_done, b_done, c_done;
  logic        a_pass, b_pass, c_pass;
  logic [31:0] a_fc, b_fc, c_fc;
  logic        a_cause, b_cause, c_cause;

  int checks = 0;
  int failures = 0;

  triumphcore_sim_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .retire_valid_i(retire), .retire_pc_i(pc),
    .dwrite_valid_i(dwv), .dwrite_addr_i(daddr), .dwrite_data_i(ddata),
    .hist_rd_idx_i(hidx), .hist_rd_pc_o(a_hpc), .hist_count_o(a_hcnt),
    .cycle_cnt_o(a_cyc), .instret_o(a_ret), .state_o(a_st), .done_o(a_done),
    .pass_o(a_pass), .fail_code_o(a_fc), .timeout_cause_o(a_cause)
  );

  triumphcore_sim_ctrl #(.STALL_LIMIT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .retire_valid_i(retire), .retire_pc_i(pc),
    .dwrite_valid_i(dwv), .dwrite_addr_i(daddr), .dwrite_data_i(ddata),
    .hist_rd_idx_i(hidx), .hist_rd_pc_o(b_hpc), .hist_count_o(b_hcnt),
    .cycle_cnt_o(b_cyc), .instret_o(b_ret), .state_o(b_st), .done_o(b_done),
    .pass_o(b_pass), .fail_code_o(b_fc), .timeout_cause_o(b_cause)
  );

  triumphcore_sim_ctrl #(.STALL_LIMIT(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .retire_valid_i(retire), .retire_pc_i(pc),
    .dwrite_valid_i(dwv), .dwrite_addr_i(daddr), .dwrite_data_i(ddata),
    .hist_rd_idx_i(hidx), .hist_rd_pc_o(c_hpc), .hist_count_o(c_hcnt),
    .cycle_cnt_o(c_cyc), .instret_o(c_ret), .state_o(c_st), .done_o(c_done),
    .pass_o(c_pass), .fail_code_o(c_fc), .timeout_cause_o(c_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdhist(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    hidx = idx;
    #1;
    chk(tag, a_hpc, exp);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    retire = 1'b0;
    dwv = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; retire = 1'b0; pc = '0; dwv = 1'b0; daddr = '0; ddata = '0; hidx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", a_st, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_cycle", a_cyc, 0);
    chk("rst_instret", a_ret, 0);
    chk("rst_hcount", a_hcnt, 0);
    chk("rst_failcode", a_fc, 0);
    chk("rst_cause", a_cause, 0);
    rst = 1'b0;

    // PASS after five retires
    for (int i = 0; i < 5; i++) begin
      retire = 1'b1;
      pc = 32'h100 + 32'(4 * i);
      tick();
    end
    retire = 1'b0;
    dwv = 1'b1; daddr = TOHOST; ddata = 32'd1;
    tick();
    dwv = 1'b0;
    chk("pass_state", a_st, 1);
    chk("pass_pass", a_pass, 1);
    chk("pass_done", a_done, 1);
    chk("pass_instret", a_ret, 5);
    chk("pass_cycle", a_cyc, 6);
    chk("pass_hcount", a_hcnt, 5);
    rdhist("pass_hist0", 3'd0, 32'h110);
    rdhist("pass_hist4", 3'd4, 32'h100);
    rdhist("pass_hist5_empty", 3'd5, 32'h0);
    retire = 1'b1; pc = 32'h200;
    tick();
    tick();
    retire = 1'b0;
    chk("pass_frozen_instret", a_ret, 5);
    chk("pass_frozen_cycle", a_cyc, 6);
    chk("pass_frozen_state", a_st, 1);
    rdhist("pass_frozen_hist0", 3'd0, 32'h110);

    // Asynchronous reset in a terminal state, checked before the next edge
    rst = 1'b1;
    #2;
    chk("arst_state", a_st, 0);
    chk("arst_done", a_done, 0);
    chk("arst_pass", a_pass, 0);
    chk("arst_cycle", a_cyc, 0);
    chk("arst_instret", a_ret, 0);
    chk("arst_hcount", a_hcnt, 0);
    rdhist("arst_hist0", 3'd0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("arst_restart0", a_cyc, 0);
    tick();
    chk("arst_restart1", a_cyc, 1);

    // FAIL and ignored writes
    rst_pulse();
    dwv = 1'b1; daddr = TOHOST; ddata = 32'h2A;
    tick();
    chk("even_ignored", a_st, 0);
    ddata = 32'h0;
    tick();
    chk("zero_ignored", a_st, 0);
    daddr = 32'h8000_1004; ddata = 32'h7;
    tick();
    chk("addr_ignored", a_st, 0);
    chk("addr_ignored_done", a_done, 0);
    daddr = TOHOST; ddata = 32'h7;
    tick();
    chk("fail_state", a_st, 2);
    chk("fail_code", a_fc, 3);
    chk("fail_pass", a_pass, 0);
    chk("fail_done", a_done, 1);
    ddata = 32'h1;
    tick();
    dwv = 1'b0;
    chk("fail_sticky", a_st, 2);
    chk("fail_code_frozen", a_fc, 3);

    // Stall timeout with STALL_LIMIT=4
    rst_pulse();
    retire = 1'b1; pc = 32'h40;
    repeat (3) tick();
    retire = 1'b0;
    repeat (3) tick();
    chk("stall_not_yet", c_st, 0);
    chk("stall_not_yet_cycle", c_cyc, 6);
    tick();
    chk("stall_state", c_st, 3);
    chk("stall_cause", c_cause, 1);
    chk("stall_cycle", c_cyc, 7);
    chk("stall_instret", c_ret, 3);
    tick();
    chk("stall_cycle_frozen", c_cyc, 7);

    // Global timeout with stall disabled, retire every cycle
    rst_pulse();
    retire = 1'b1; pc = 32'h80;
    repeat (249) tick();
    chk("gto_not_yet", b_st, 0);
    chk("gto_not_yet_cycle", b_cyc, 249);
    tick();
    chk("gto_state", b_st, 3);
    chk("gto_cause", b_cause, 0);
    chk("gto_cycle", b_cyc, 250);
    chk("gto_instret", b_ret, 250);
    chk("gto_done", b_done, 1);
    chk("gto_default_state", a_st, 3);
    tick();
    retire = 1'b0;
    chk("gto_cycle_frozen", b_cyc, 250);
    chk("gto_instret_frozen", b_ret, 250);

    // History wrap, then tohost PASS on the same edge as the global timeout
    rst_pulse();
    for (int i = 0; i < 10; i++) begin
      retire = 1'b1;
      pc = 32'(4 * i);
      tick();
    end
    chk("wrap_hcount", a_hcnt, 8);
    rdhist("wrap_hist0", 3'd0, 32'h24);
    rdhist("wrap_hist1", 3'd1, 32'h20);
    rdhist("wrap_hist7", 3'd7, 32'h8);
    pc = 32'h3000;
    repeat (239) tick();
    chk("prio_not_yet", a_st, 0);
    chk("prio_cycle_249", a_cyc, 249);
    chk("prio_hcount_sat", a_hcnt, 8);
    pc = 32'h4000;
    dwv = 1'b1; daddr = TOHOST; ddata = 32'd1;
    tick();
    dwv = 1'b0; retire = 1'b0;
    chk("prio_state", a_st, 1);
    chk("prio_cycle", a_cyc, 250);
    chk("prio_instret", a_ret, 250);
    rdhist("prio_hist0", 3'd0, 32'h4000);
    chk("prio_nostall_state", b_st, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
